// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported RAM between instruction fetch and data ports; data wins unless an instruction has waited MAX_DSTREAK data grants.
// Latency: strobe one cycle after request, one IDLE bubble between grants; backpressure: iwait/dwait stay high until RAM reports ACCESS.
module mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int MAX_DSTREAK = 4
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic [ADDR_W-1:0] iload,
   output logic              iwait,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [ADDR_W-1:0] dstore,
   output logic [ADDR_W-1:0] dload,
   output logic              dwait,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [ADDR_W-1:0] ramstore,
   input  logic [ADDR_W-1:0] ramload,
   input  logic [1:0]        ramstate
);

   localparam int SW = $clog2(MAX_DSTREAK + 1);
   localparam logic [SW-1:0] MAX_S = SW'(MAX_DSTREAK);
   localparam logic [1:0] RAM_ACCESS = 2'b10;

   typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

   state_t        state, next_state;
   logic [SW-1:0] streak, next_streak;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= IDLE;
         streak <= '0;
      end else begin
         state  <= next_state;
         streak <= next_streak;
      end
   end

   always_comb begin
      next_state  = state;
      next_streak = streak;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      iwait       = 1'b1;
      dwait       = 1'b1;
      iload       = '0;
      dload       = '0;
      case (state)
         IDLE: begin
            if ((dREN | dWEN) && !(iREN && streak == MAX_S))
               next_state = DGRANT;
            else if (iREN)
               next_state = IGRANT;
         end
         IGRANT: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            // A withdrawn request leaves quietly: no completion, streak untouched.
            if (!iREN) begin
               next_state = IDLE;
            end else if (ramstate == RAM_ACCESS) begin
               iwait       = 1'b0;
               iload       = ramload;
               next_state  = IDLE;
               next_streak = '0;
            end
         end
         DGRANT: begin
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (!(dREN | dWEN)) begin
               next_state = IDLE;
            end else if (ramstate == RAM_ACCESS) begin
               dwait      = 1'b0;
               dload      = dWEN ? '0 : ramload;
               next_state = IDLE;
               if (!iREN)
                  next_streak = '0;
               else if (streak != MAX_S)
                  next_streak = streak + 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: bench drives ramstate/ramload cycle by cycle and checks against hand-computed values.
module tb_mem_arbiter;

   localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACC = 2'b10, ERR = 2'b11;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic        iwait, dwait, ramREN, ramWEN;
   logic [1:0]  ramstate;

   int n_cmp = 0;
   int n_err = 0;

   mem_arbiter #(.ADDR_W(32), .MAX_DSTREAK(4)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   // Advance one clock; inputs are driven 1 ns after the edge, checks follow 1 ns later.
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
      iaddr = 0; daddr = 0; dstore = 0; ramload = 32'hA5A5_A5A5; ramstate = FREE;
      #12;
      n_cmp++;
      if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
         n_err++; $display("FAIL reset_ctl got=%b want=0011", {ramREN, ramWEN, iwait, dwait});
      end
      n_cmp++;
      if ({ramaddr, ramstore, iload, dload} !== 128'd0) begin
         n_err++; $display("FAIL reset_data got=%h want=0", {ramaddr, ramstore, iload, dload});
      end
      n_cmp++;
      if (dut.streak !== 3'd0) begin
         n_err++; $display("FAIL reset_streak got=%0d want=0", dut.streak);
      end
      nRST = 1'b1;
   endtask

   task automatic test_ifetch();
      cyc(); iREN = 1; iaddr = 32'h0000_0040; ramstate = BUSY; #1;
      n_cmp++;
      if (ramREN !== 1'b0) begin
         n_err++; $display("FAIL ifetch_idle ramREN got=%b want=0", ramREN);
      end
      for (int c = 1; c <= 3; c++) begin
         cyc();
         if (c == 3) begin ramstate = ACC; ramload = 32'h2408_0001; end
         #1;
         n_cmp++;
         if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h40}) begin
            n_err++; $display("FAIL ifetch_strobe c%0d got=%b%b %h want=10 00000040", c, ramREN, ramWEN, ramaddr);
         end
         n_cmp++;
         if ({iwait, iload} !== ((c == 3) ? {1'b0, 32'h2408_0001} : {1'b1, 32'h0})) begin
            n_err++; $display("FAIL ifetch_wait c%0d got=%b %h", c, iwait, iload);
         end
      end
      cyc(); iREN = 0; ramstate = FREE; #1;
      n_cmp++;
      if ({ramREN, iwait} !== 2'b01) begin
         n_err++; $display("FAIL ifetch_drop got=%b want=01", {ramREN, iwait});
      end
   endtask

   task automatic test_simultaneous();
      cyc(); iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h100; #1;
      cyc(); ramstate = ACC; ramload = 32'hDEAD_BEEF; #1;
      n_cmp++;
      if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h100}) begin
         n_err++; $display("FAIL simul_dgrant got=%b%b %h want=10 00000100", ramREN, ramWEN, ramaddr);
      end
      n_cmp++;
      if ({dwait, dload, iwait} !== {1'b0, 32'hDEAD_BEEF, 1'b1}) begin
         n_err++; $display("FAIL simul_dcomp got=%b %h %b want=0 deadbeef 1", dwait, dload, iwait);
      end
      cyc(); dREN = 0; #1;
      n_cmp++;
      if ({ramREN, iwait, dwait} !== 3'b011) begin
         n_err++; $display("FAIL simul_bubble got=%b want=011", {ramREN, iwait, dwait});
      end
      cyc(); ramload = 32'h0BAD_F00D; #1;
      n_cmp++;
      if ({ramREN, ramaddr, iwait, iload} !== {1'b1, 32'h44, 1'b0, 32'h0BAD_F00D}) begin
         n_err++; $display("FAIL simul_igrant got=%b %h %b %h", ramREN, ramaddr, iwait, iload);
      end
      cyc(); iREN = 0; ramstate = FREE; #1;
   endtask

   task automatic test_streak();
      int dcount = 0;
      cyc(); iREN = 1; dREN = 1; iaddr = 32'h80; daddr = 32'h180;
      ramstate = ACC; ramload = 32'h1111_2222; #1;
      for (int g = 0; g < 5; g++) begin
         cyc(); #1;
         if (!dwait) dcount++;
         n_cmp++;
         if ({iwait, dwait} !== ((g < 4) ? 2'b10 : 2'b01)) begin
            n_err++; $display("FAIL streak_grant g%0d got=%b want=%b", g, {iwait, dwait}, (g < 4) ? 2'b10 : 2'b01);
         end
         cyc(); #1;
         n_cmp++;
         if (dut.streak !== ((g < 4) ? 3'(g + 1) : 3'd0)) begin
            n_err++; $display("FAIL streak_count g%0d got=%0d want=%0d", g, dut.streak, (g < 4) ? g + 1 : 0);
         end
      end
      n_cmp++;
      if (dcount !== 4) begin
         n_err++; $display("FAIL streak_dcount got=%0d want=4", dcount);
      end
      iREN = 0; dREN = 0; ramstate = FREE;
   endtask

   task automatic test_write_busy();
      cyc(); dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'h1234_5678;
      ramstate = BUSY; ramload = 32'hFFFF_FFFF; #1;
      for (int c = 1; c <= 4; c++) begin
         cyc();
         if (c == 4) ramstate = ACC;
         #1;
         n_cmp++;
         if ({ramREN, ramWEN, ramaddr, ramstore} !== {2'b01, 32'h200, 32'h1234_5678}) begin
            n_err++; $display("FAIL write_strobe c%0d got=%b%b %h %h", c, ramREN, ramWEN, ramaddr, ramstore);
         end
         n_cmp++;
         if ({dwait, dload} !== {(c != 4), 32'h0}) begin
            n_err++; $display("FAIL write_wait c%0d got=%b %h want=%b 0", c, dwait, dload, c != 4);
         end
      end
      cyc(); dREN = 0; dWEN = 0; ramstate = FREE; #1;
   endtask

   task automatic test_error();
      cyc(); iREN = 1; iaddr = 32'hC0; ramstate = ERR; ramload = 32'h5555_AAAA; #1;
      for (int c = 1; c <= 3; c++) begin
         cyc();
         if (c == 3) ramstate = ACC;
         #1;
         n_cmp++;
         if ({ramREN, iwait} !== {1'b1, (c != 3)}) begin
            n_err++; $display("FAIL error_c%0d got=%b want=1%b", c, {ramREN, iwait}, c != 3);
         end
      end
      cyc(); iREN = 0; #1;
      for (int c = 0; c < 2; c++) begin
         n_cmp++;
         if ({ramREN, iwait} !== 2'b01) begin
            n_err++; $display("FAIL error_extra c%0d got=%b want=01", c, {ramREN, iwait});
         end
         cyc(); #1;
      end
      ramstate = FREE;
   endtask

   task automatic test_async_reset();
      cyc(); iREN = 1; dREN = 1; daddr = 32'h300; ramstate = ACC; #1;
      cyc(); #1;
      cyc(); ramstate = BUSY; #1;
      cyc(); #1;
      n_cmp++;
      if ({ramREN, ramaddr, dut.streak} !== {1'b1, 32'h300, 3'd1}) begin
         n_err++; $display("FAIL areset_pre got=%b %h %0d want=1 00000300 1", ramREN, ramaddr, dut.streak);
      end
      #1 nRST = 1'b0;
      #1;
      n_cmp++;
      if ({ramREN, ramWEN, dwait, ramaddr, dut.streak} !== {3'b001, 32'h0, 3'd0}) begin
         n_err++; $display("FAIL areset_drop got=%b%b%b %h %0d", ramREN, ramWEN, dwait, ramaddr, dut.streak);
      end
      iREN = 0;
      #2 nRST = 1'b1;
      cyc(); #1;
      n_cmp++;
      if ({ramREN, ramaddr} !== {1'b1, 32'h300}) begin
         n_err++; $display("FAIL areset_regrant got=%b %h want=1 00000300", ramREN, ramaddr);
      end
      dREN = 0; ramstate = FREE;
   endtask

   initial begin
      test_reset();
      test_ifetch();
      test_simultaneous();
      test_streak();
      test_write_busy();
      test_error();
      test_async_reset();
      cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
